mem_access_sequencer: RTL and testbench

Sits between the EX/MEM pipeline register and the little-endian data memory (`memTopo32LittleEndian`), as the memory-stage request sequencer. It accepts one load/store request per handshake. Aligned requests go to memory as a single access. Misaligned halfword/word requests are split into consecutive byte accesses, and load bytes are reassembled, then sign- or zero-extended. While it is busy it holds `req_ready` low, and the pipeline uses that low level as its memory stall.

---
 rtl/mem_access_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// Memory-stage load/store sequencer: aligned requests issue one access; misaligned
// half/word requests are split into byte accesses and the load bytes are reassembled.
module mem_access_sequencer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [1:0]               mem_size,
  output logic                     mem_sign_ext,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_din,
  input  logic [DATA_WIDTH-1:0]    mem_dout
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned KW = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   last_q, last_d;
  logic            split_q, split_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   asm_q, asm_d;

  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [1:0]      mem_size_q, mem_size_d;
  logic            mem_sign_ext_q, mem_sign_ext_d;
  logic            mem_we_q, mem_we_d;
  logic [DW-1:0]   mem_din_q, mem_din_d;

  // Issue selection: which request fields drive the next registered memory access
  logic            iss;
  logic [AW-1:0]   iss_addr;
  logic            iss_we;
  logic [2:0]      iss_f3;
  logic [DW-1:0]   iss_wdata;
  logic            iss_split;
  logic [KW-1:0]   iss_k;

  logic            req_split;
  logic [KW-1:0]   req_last;
  logic            req_illegal;
  logic [DW-1:0]   asm_nx;
  logic [DW-1:0]   rd_ext;

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    last_d         = last_q;
    split_d        = split_q;
    addr_d         = addr_q;
    we_d           = we_q;
    funct3_d       = funct3_q;
    wdata_d        = wdata_q;
    asm_d          = asm_q;
    resp_valid_d   = 1'b0;
    resp_err_d     = 1'b0;
    resp_rdata_d   = '0;
    mem_addr_d     = '0;
    mem_size_d     = 2'b00;
    mem_sign_ext_d = 1'b0;
    mem_we_d       = 1'b0;
    mem_din_d      = '0;
    iss            = 1'b0;
    iss_addr       = addr_q;
    iss_we         = we_q;
    iss_f3         = funct3_q;
    iss_wdata      = wdata_q;
    iss_split      = split_q;
    iss_k          = k_q;
    req_split      = 1'b0;
    req_last       = '0;
    req_illegal    = 1'b0;

    // Access count of the incoming request, encoded as last byte index
    case (req_funct3[1:0])
      2'b00: ;
      2'b01: begin
        req_split = req_addr[0];
        req_last  = req_addr[0] ? KW'(1) : KW'(0);
      end
      2'b10: begin
        req_split = |req_addr[1:0];
        req_last  = req_split ? KW'(3) : KW'(0);
      end
      default: req_illegal = 1'b1;
    endcase

    asm_nx = asm_q;
    if (split_q) asm_nx[{k_q, 3'b000} +: 8] = mem_dout[7:0];
    else         asm_nx = mem_dout;

    // Split halfword loads extend here; aligned loads come back extended by the memory
    rd_ext = asm_nx;
    if (split_q && (funct3_q[1:0] == 2'b01))
      rd_ext[31:16] = funct3_q[2] ? 16'h0000 : {16{asm_nx[15]}};

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d   = req_addr;
          we_d     = req_we;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          k_d      = '0;
          asm_d    = '0;
          split_d  = req_split;
          last_d   = req_last;
          if (req_illegal) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d   = S_ACCESS;
            iss       = 1'b1;
            iss_addr  = req_addr;
            iss_we    = req_we;
            iss_f3    = req_funct3;
            iss_wdata = req_wdata;
            iss_split = req_split;
            iss_k     = '0;
          end
        end
      end
      S_ACCESS: begin
        asm_d = asm_nx;
        if (k_q == last_q) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? '0 : rd_ext;
        end else begin
          k_d   = k_q + KW'(1);
          iss   = 1'b1;
          iss_k = k_q + KW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (iss) begin
      mem_we_d   = iss_we;
      mem_addr_d = iss_addr + AW'(iss_k);
      if (iss_split) begin
        mem_size_d     = 2'b00;
        mem_sign_ext_d = 1'b1;
        mem_din_d      = {4{iss_wdata[{iss_k, 3'b000} +: 8]}};
      end else begin
        mem_size_d     = iss_f3[1:0];
        mem_sign_ext_d = iss_f3[2];
        case (iss_f3[1:0])
          2'b00:   mem_din_d = {4{iss_wdata[7:0]}};
          2'b01:   mem_din_d = {2{iss_wdata[15:0]}};
          default: mem_din_d = iss_wdata;
        endcase
      end
    end

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      k_q            <= '0;
      last_q         <= '0;
      split_q        <= 1'b0;
      addr_q         <= '0;
      we_q           <= 1'b0;
      funct3_q       <= 3'b000;
      wdata_q        <= '0;
      asm_q          <= '0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= '0;
      mem_addr_q     <= '0;
      mem_size_q     <= 2'b00;
      mem_sign_ext_q <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_din_q      <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      last_q         <= last_d;
      split_q        <= split_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      funct3_q       <= funct3_d;
      wdata_q        <= wdata_d;
      asm_q          <= asm_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      resp_rdata_q   <= resp_rdata_d;
      mem_addr_q     <= mem_addr_d;
      mem_size_q     <= mem_size_d;
      mem_sign_ext_q <= mem_sign_ext_d;
      mem_we_q       <= mem_we_d;
      mem_din_q      <= mem_din_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_size     = mem_size_q;
  assign mem_sign_ext = mem_sign_ext_q;
  assign mem_we       = mem_we_q;
  assign mem_din      = mem_din_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a small little-endian byte memory model.
module tb_mem_access_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [5:0]  mem_addr;
  logic [1:0]  mem_size;
  logic        mem_sign_ext;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int checks = 0;
  int passes = 0;

  mem_access_sequencer #(.DATA_WIDTH(32), .ADDRESS_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_sign_ext(mem_sign_ext),
    .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: writes on the rising edge, combinational raw read (no extension)
  logic [7:0] mem [64];
  logic [5:0] a1, a2, a3;
  assign a1 = mem_addr + 6'd1;
  assign a2 = mem_addr + 6'd2;
  assign a3 = mem_addr + 6'd3;

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_size)
        2'b00: mem[mem_addr] <= mem_din[7:0];
        2'b01: begin mem[mem_addr] <= mem_din[7:0]; mem[a1] <= mem_din[15:8]; end
        default: begin
          mem[mem_addr] <= mem_din[7:0];  mem[a1] <= mem_din[15:8];
          mem[a2] <= mem_din[23:16]; mem[a3] <= mem_din[31:24];
        end
      endcase
    end
  end

  always_comb begin
    case (mem_size)
      2'b00:   mem_dout = {24'h0, mem[mem_addr]};
      2'b01:   mem_dout = {16'h0, mem[a1], mem[mem_addr]};
      default: mem_dout = {mem[a3], mem[a2], mem[a1], mem[mem_addr]};
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one accept edge; returns #1 into cycle 1
  task automatic issue(input logic we, input logic [2:0] f3, input logic [5:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    #12;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready); else passes++;
    checks++; if ({resp_valid, resp_err, mem_we} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {resp_valid, resp_err, mem_we}); else passes++;
    checks++; if ({resp_rdata, mem_din, mem_addr, mem_size, mem_sign_ext} !== 73'h0) $display("FAIL reset_data got=%h exp=0", {resp_rdata, mem_din, mem_addr, mem_size, mem_sign_ext}); else passes++;
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_aligned_word();
    issue(1'b1, 3'b010, 6'h08, 32'hDEADBEEF);
    checks++; if ({mem_we, mem_size, mem_addr} !== {1'b1, 2'b10, 6'h08}) $display("FAIL al_st_ctl got=%b/%b/%h exp=1/10/08", mem_we, mem_size, mem_addr); else passes++;
    checks++; if (mem_din !== 32'hDEADBEEF) $display("FAIL al_st_din got=%h exp=deadbeef", mem_din); else passes++;
    checks++; if (req_ready !== 1'b0) $display("FAIL al_st_busy got=%b exp=0", req_ready); else passes++;
    step();
    checks++; if ({resp_valid, resp_err, mem_we} !== 3'b100) $display("FAIL al_st_resp got=%b exp=100", {resp_valid, resp_err, mem_we}); else passes++;
    checks++; if (resp_rdata !== 32'h0) $display("FAIL al_st_rdata got=%h exp=0", resp_rdata); else passes++;
    checks++; if ({mem[11], mem[10], mem[9], mem[8]} !== 32'hDEADBEEF) $display("FAIL al_st_mem got=%h exp=deadbeef", {mem[11], mem[10], mem[9], mem[8]}); else passes++;
    step();
    checks++; if ({req_ready, resp_valid} !== 2'b10) $display("FAIL al_st_idle got=%b exp=10", {req_ready, resp_valid}); else passes++;
    issue(1'b0, 3'b010, 6'h08, 32'h0);
    checks++; if ({mem_we, resp_valid} !== 2'b00) $display("FAIL al_ld_c1 got=%b exp=00", {mem_we, resp_valid}); else passes++;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) $display("FAIL al_ld_resp got=%b/%h exp=1/deadbeef", resp_valid, resp_rdata); else passes++;
    step();
  endtask

  task automatic test_misaligned_word();
    logic [7:0] eb [4];
    eb[0] = 8'h44; eb[1] = 8'h33; eb[2] = 8'h22; eb[3] = 8'h11;
    issue(1'b1, 3'b010, 6'h05, 32'h11223344);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_we, mem_size, mem_sign_ext, mem_addr, mem_din} !== {1'b1, 2'b00, 1'b1, 6'(5 + i), {4{eb[i]}}})
        $display("FAIL mw_st_cyc%0d got=%b/%b/%b/%h/%h exp=1/00/1/%h/%h", i + 1, mem_we, mem_size, mem_sign_ext, mem_addr, mem_din, 6'(5 + i), {4{eb[i]}});
      else passes++;
      step();
    end
    checks++; if ({resp_valid, mem_we} !== 2'b10) $display("FAIL mw_st_resp got=%b exp=10", {resp_valid, mem_we}); else passes++;
    checks++; if ({mem[8], mem[7], mem[6], mem[5]} !== 32'h11223344) $display("FAIL mw_st_mem got=%h exp=11223344", {mem[8], mem[7], mem[6], mem[5]}); else passes++;
    step();
    issue(1'b0, 3'b010, 6'h05, 32'h0);
    step(); step(); step();
    checks++; if (resp_valid !== 1'b0) $display("FAIL mw_ld_early got=%b exp=0", resp_valid); else passes++;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h11223344) $display("FAIL mw_ld_resp got=%b/%h exp=1/11223344", resp_valid, resp_rdata); else passes++;
    step();
  endtask

  task automatic test_half_ext();
    issue(1'b1, 3'b000, 6'h03, 32'h00000080);
    checks++; if ({mem_size, mem_din} !== {2'b00, 32'h80808080}) $display("FAIL sb_din got=%b/%h exp=00/80808080", mem_size, mem_din); else passes++;
    step(); step();
    issue(1'b1, 3'b000, 6'h04, 32'h123456FF);
    step(); step();
    issue(1'b0, 3'b001, 6'h03, 32'h0);
    step();
    checks++; if (resp_valid !== 1'b0) $display("FAIL lh_early got=%b exp=0", resp_valid); else passes++;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFFFF80) $display("FAIL lh_sext got=%b/%h exp=1/ffffff80", resp_valid, resp_rdata); else passes++;
    step();
    issue(1'b0, 3'b101, 6'h03, 32'h0);
    step(); step();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000FF80) $display("FAIL lhu_zext got=%b/%h exp=1/0000ff80", resp_valid, resp_rdata); else passes++;
    step();
  endtask

  task automatic test_wrap();
    logic [5:0] ea [4];
    ea[0] = 6'h3E; ea[1] = 6'h3F; ea[2] = 6'h00; ea[3] = 6'h01;
    issue(1'b1, 3'b010, 6'h3E, 32'hA1B2C3D4);
    for (int i = 0; i < 4; i++) begin
      checks++; if ({mem_we, mem_addr} !== {1'b1, ea[i]}) $display("FAIL wrap_addr%0d got=%b/%h exp=1/%h", i, mem_we, mem_addr, ea[i]); else passes++;
      step();
    end
    checks++; if ({mem[1], mem[0], mem[63], mem[62]} !== 32'hA1B2C3D4) $display("FAIL wrap_mem got=%h exp=a1b2c3d4", {mem[1], mem[0], mem[63], mem[62]}); else passes++;
    step();
  endtask

  task automatic test_illegal();
    issue(1'b1, 3'b011, 6'h10, 32'hFFFFFFFF);
    checks++; if ({resp_valid, resp_err, mem_we} !== 3'b110) $display("FAIL ill_resp got=%b exp=110", {resp_valid, resp_err, mem_we}); else passes++;
    checks++; if (resp_rdata !== 32'h0) $display("FAIL ill_rdata got=%h exp=0", resp_rdata); else passes++;
    step();
    checks++; if ({req_ready, resp_valid, resp_err} !== 3'b100) $display("FAIL ill_after got=%b exp=100", {req_ready, resp_valid, resp_err}); else passes++;
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 6'h21; req_wdata = 32'h55667788;
    step();
    req_addr = 6'h30; req_funct3 = 3'b000; req_wdata = 32'h00000099;
    for (int c = 1; c <= 5; c++) begin
      checks++; if (req_ready !== 1'b0) $display("FAIL busy_ready_c%0d got=%b exp=0", c, req_ready); else passes++;
      if (c <= 4) begin
        checks++; if (mem_addr !== 6'(6'h21 + c - 1)) $display("FAIL busy_addr_c%0d got=%h exp=%h", c, mem_addr, 6'(6'h21 + c - 1)); else passes++;
      end
      step();
    end
    checks++; if ({req_ready, mem_we} !== 2'b10) $display("FAIL busy_idle got=%b exp=10", {req_ready, mem_we}); else passes++;
    step();
    req_valid = 1'b0;
    checks++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 6'h30, 32'h99999999}) $display("FAIL second_req got=%b/%h/%h exp=1/30/99999999", mem_we, mem_addr, mem_din); else passes++;
    step(); step();
    checks++; if ({mem[6'h24], mem[6'h23], mem[6'h22], mem[6'h21], mem[6'h30]} !== 40'h5566778899) $display("FAIL busy_mem got=%h exp=5566778899", {mem[6'h24], mem[6'h23], mem[6'h22], mem[6'h21], mem[6'h30]}); else passes++;
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 3'b010, 6'h28, 32'h0);
    step(); step();
    issue(1'b1, 3'b010, 6'h2C, 32'h0);
    step(); step();
    issue(1'b1, 3'b010, 6'h29, 32'hCAFEBABE);
    step();
    checks++; if ({mem_we, mem_addr} !== {1'b1, 6'h2A}) $display("FAIL rst_pre got=%b/%h exp=1/2a", mem_we, mem_addr); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_we, req_ready, mem_addr} !== {1'b0, 1'b1, 6'h00}) $display("FAIL rst_async got=%b/%b/%h exp=0/1/00", mem_we, req_ready, mem_addr); else passes++;
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if ({resp_valid, mem_we, req_ready} !== 3'b001) $display("FAIL rst_quiet_c%0d got=%b exp=001", c, {resp_valid, mem_we, req_ready}); else passes++;
    end
    checks++; if ({mem[6'h2C], mem[6'h2B], mem[6'h2A], mem[6'h29]} !== 32'h000000BE) $display("FAIL rst_mem got=%h exp=000000be", {mem[6'h2C], mem[6'h2B], mem[6'h2A], mem[6'h29]}); else passes++;
  endtask

  initial begin
    test_reset();
    test_aligned_word();
    test_misaligned_word();
    test_half_ext();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
